dendrite_integrator: RTL and testbench
======================================

// Module: dendrite_integrator
// PURPOSE
//  Upstream stage of the soma. Accepts presynaptic spike events (address-event, valid/ready).
//  Looks up each event's synaptic weight in a local weight table.
//  Integrates signed contributions over one timestep.
//  On each timestep tick, hands the soma a clamped 8-bit weight sum plus an event count (soma in_spike).
// PARAMETERS
//  N_SYN    16              number of presynaptic inputs (weight table entries)
//  AW       $clog2(N_SYN)   event/write address width
//  W_W      8               weight magnitude width (= soma weight width)
//  ACC_IW   W_W+4           internal signed accumulator width
// PORTS
//  clk          in   1      clock
//  rst          in   1      asynchronous, active-low reset
//  ev_valid     in   1      presynaptic event present
//  ev_ready     out  1      event accepted when ev_valid & ev_ready
//  ev_addr      in   AW     presynaptic index
//  gate         in   1      soma suspend/refractory: accepted events counted, weights discarded
//  tick         in   1      timestep boundary strobe (1 cycle)
//  wr_en        in   1      weight table write
//  wr_addr      in   AW     write index
//  wr_data      in   W_W    weight magnitude
//  wr_inh       in   1      1 = inhibitory synapse (contribution subtracted)
//  out_valid    out  1      1-cycle pulse, timestep result valid
//  out_weight   out  W_W    clamped sum to soma weight
//  out_count    out  8      events accepted this step, saturating (to soma in_spike)
//  tick_overrun out  1      sticky: a tick was lost
// BEHAVIOUR
//  Reset: table entries 0/excitatory.
//   acc=0, count=0, out_valid=0, out_weight=0, out_count=0, tick_overrun=0, ev_ready=0.
//   In-flight events are discarded; ev_ready rises the first cycle after rst deasserts.
//  FSM states:
//   ACCUM: ev_ready=1; on tick (or pending tick) -> DRAIN.
//   DRAIN: ev_ready=0; one cycle, lets the stage-1 event retire into acc -> EMIT.
//   EMIT: ev_ready=0; out_valid=1 with outputs latched from acc/count; acc,count cleared -> ACCUM.
//  Latency: tick in ACCUM at cycle T -> out_valid at T+2.
//   Event accepted at T is included; events at T+1/T+2 are not accepted (ready low).
//  Pipeline: S1 = accept + registered table read; S2 = accumulate. Sustained 1 event/cycle in ACCUM.
//  Accumulate: acc += inh ? -w : +w, saturating at signed ACC_IW bounds.
//   gate=1 at accept: count increments, acc unchanged.
//   count saturates at 255.
//  Clamp at EMIT: acc<0 -> 0; acc>2^W_W-1 -> 2^W_W-1; else acc[W_W-1:0].
//  Tick outside ACCUM: held as one pending tick, served on return to ACCUM.
//   A tick while a pending tick is already held is dropped and sets tick_overrun (cleared only by reset).
//  out_weight/out_count hold their value between pulses.
//  Write vs read at the same address in the same cycle: read returns the OLD entry.
//   Writes are accepted in every state.
//  ev_addr >= N_SYN: event accepted, counted, weight treated as 0.
// STRUCTURE
//  Shared package neuron_pkg:
//   W_W, state encoding ACCUM/DRAIN/EMIT, and the clamp/saturate function (also reused by soma).
//  Sub-module synapse_weight_ram: N_SYN x (W_W+1) register file.
//   One write port, one registered read port, read-before-write.
//  Top level: FSM, S1/S2 pipeline regs, accumulator, output regs.
// TESTING
//  T1: w[3]=10 exc; 5 events addr3 back-to-back, tick
//      -> out_valid 2 cycles after tick; out_weight=50, out_count=5.
//  T2: w[1]=200 exc, w[2]=100 inh; events 1,1,2,tick -> acc=300 clamps to 255.
//      Next step: events 2,2,2,tick -> out_weight=0, out_count=3.
//  T3: gate=1; 4 events addr3 (w=10), tick -> out_weight=0, out_count=4.
//  T4: event accepted in the same cycle as tick -> included.
//      ev_valid held through DRAIN/EMIT -> not accepted until ACCUM; counted next step.
//  T5: tick in DRAIN, then another tick in EMIT -> one pending served (second out_valid), tick_overrun=1.
//      wr_en to addr5 while an addr5 event is read -> old weight used.
//  T6: rst asserted mid-step with events in S1/S2
//      -> all outputs 0 immediately; after release, tick gives out_weight=0, out_count=0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared neuron definitions: weight width, timestep FSM encoding and the
// saturating helper used by both the dendrite integrator and the soma.
package neuron_pkg;

    localparam int unsigned W_W   = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2
    } step_state_t;

    // Saturate v into [lo, hi]; doubles as the output clamp with lo = 0.
    function automatic int sat_int(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/synapse_weight_ram.sv
// Synaptic weight register file: one write port, one registered read port,
// read-before-write on an address collision. Entry = {inhibitory, magnitude}.
module synapse_weight_ram #(
    parameter int unsigned N_SYN = 16,
    parameter int unsigned AW    = $clog2(N_SYN),
    parameter int unsigned DW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [N_SYN];
    logic          wr_ok;
    logic          rd_ok;

    if (N_SYN < (2 ** AW)) begin : g_range
        assign wr_ok = (32'(wr_addr) < N_SYN);
        assign rd_ok = (32'(rd_addr) < N_SYN);
    end else begin : g_full
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem     <= '{default: '0};
            rd_data <= '0;
        end else begin
            if (wr_en && wr_ok) mem[wr_addr] <= wr_data;
            if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/dendrite_integrator.sv
// Dendrite integrator: accepts presynaptic address events, accumulates signed
// synaptic weights per timestep and hands the soma a clamped sum and event count.
module dendrite_integrator #(
    parameter int unsigned N_SYN  = 16,
    parameter int unsigned AW     = $clog2(N_SYN),
    parameter int unsigned W_W    = neuron_pkg::W_W,
    parameter int unsigned ACC_IW = W_W + 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ev_valid,
    output logic           ev_ready,
    input  logic [AW-1:0]  ev_addr,
    input  logic           gate,
    input  logic           tick,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W_W-1:0] wr_data,
    input  logic           wr_inh,
    output logic           out_valid,
    output logic [W_W-1:0] out_weight,
    output logic [7:0]     out_count,
    output logic           tick_overrun
);

    import neuron_pkg::*;

    localparam int ACC_MAX = (1 <<< (ACC_IW - 1)) - 1;
    localparam int ACC_MIN = -(1 <<< (ACC_IW - 1));
    localparam int OUT_MAX = (1 <<< W_W) - 1;

    step_state_t             state, state_nxt;
    logic                    pend, pend_nxt;
    logic                    overrun_nxt;
    logic                    accept;
    logic                    ev_oob;
    logic                    s1_valid, s1_gate, s1_oob;
    logic [W_W:0]            s1_entry;
    logic signed [ACC_IW-1:0] acc, acc_nxt;
    logic [7:0]              cnt, cnt_nxt;
    int                      delta;

    assign accept = ev_valid & ev_ready;

    if (N_SYN < (2 ** AW)) begin : g_oob
        assign ev_oob = (32'(ev_addr) >= N_SYN);
    end else begin : g_no_oob
        assign ev_oob = 1'b0;
    end

    synapse_weight_ram #(
        .N_SYN (N_SYN),
        .AW    (AW),
        .DW    (W_W + 1)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_inh, wr_data}),
        .rd_en   (accept),
        .rd_addr (ev_addr),
        .rd_data (s1_entry)
    );

    // Stage 2: fold the retiring stage-1 event into the running sum and count.
    always_comb begin
        delta = 0;
        if (s1_valid && !s1_gate && !s1_oob)
            delta = s1_entry[W_W] ? -int'(s1_entry[W_W-1:0]) : int'(s1_entry[W_W-1:0]);
        acc_nxt = ACC_IW'(sat_int(int'(acc) + delta, ACC_MIN, ACC_MAX));
        cnt_nxt = (s1_valid && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
    end

    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend;
        overrun_nxt = tick_overrun;
        unique case (state)
            ACCUM: if (tick || pend) begin
                state_nxt = DRAIN;
                pend_nxt  = tick && pend;
            end
            DRAIN:   state_nxt = EMIT;
            EMIT:    state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
        // Only one tick can wait for the step in progress; a second is lost.
        if (state != ACCUM && tick) begin
            if (pend) overrun_nxt = 1'b1;
            else      pend_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ACCUM;
            pend         <= 1'b0;
            tick_overrun <= 1'b0;
            ev_ready     <= 1'b0;
            s1_valid     <= 1'b0;
            s1_gate      <= 1'b0;
            s1_oob       <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_weight   <= '0;
            out_count    <= '0;
        end else begin
            state        <= state_nxt;
            pend         <= pend_nxt;
            tick_overrun <= overrun_nxt;
            ev_ready     <= (state_nxt == ACCUM);
            s1_valid     <= accept;
            s1_gate      <= gate;
            s1_oob       <= ev_oob;
            out_valid    <= (state == DRAIN);
            if (state == EMIT) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
            end
            // Results are captured from the final DRAIN update so they are valid during EMIT.
            if (state == DRAIN) begin
                out_weight <= W_W'(sat_int(int'(acc_nxt), 0, OUT_MAX));
                out_count  <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dendrite_integrator.sv
// Directed bench for dendrite_integrator: a vector table of single-synapse
// timesteps plus hand-written multi-cycle sequences.
module tb_dendrite_integrator;

    localparam int unsigned N_SYN = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned W_W   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ev_valid = 1'b0;
    logic           ev_ready;
    logic [AW-1:0]  ev_addr = '0;
    logic           gate = 1'b0;
    logic           tick = 1'b0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [W_W-1:0] wr_data = '0;
    logic           wr_inh = 1'b0;
    logic           out_valid;
    logic [W_W-1:0] out_weight;
    logic [7:0]     out_count;
    logic           tick_overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int addr;
        int w;
        bit inh;
        bit gate;
        int n;
        int ew;
        int ec;
    } vec_t;

    vec_t vecs[9];

    dendrite_integrator #(
        .N_SYN (N_SYN),
        .AW    (AW),
        .W_W   (W_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_addr      (ev_addr),
        .gate         (gate),
        .tick         (tick),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_inh       (wr_inh),
        .out_valid    (out_valid),
        .out_weight   (out_weight),
        .out_count    (out_count),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input int w, input bit inh);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = W_W'(w);
        wr_inh  = inh;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ev_ready && n < 20) begin
            cyc();
            n++;
        end
        chk({name, "_ready"}, int'(ev_ready), 1);
    endtask

    task automatic events(input int a, input bit g, input int n);
        for (int i = 0; i < n; i++) begin
            ev_valid = 1'b1;
            ev_addr  = AW'(a);
            gate     = g;
            cyc();
        end
        ev_valid = 1'b0;
        gate     = 1'b0;
    endtask

    task automatic tick_and_check(input string name, input int ew, input int ec);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk({name, "_drain_valid"}, int'(out_valid), 0);
        chk({name, "_drain_ready"}, int'(ev_ready), 0);
        cyc();
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_weight"}, int'(out_weight), ew);
        chk({name, "_count"}, int'(out_count), ec);
        cyc();
        chk({name, "_pulse_end"}, int'(out_valid), 0);
        chk({name, "_hold"}, int'(out_weight), ew);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0] = '{addr: 3,  w: 10,  inh: 0, gate: 0, n: 5,   ew: 50,  ec: 5};
        vecs[1] = '{addr: 3,  w: 10,  inh: 0, gate: 1, n: 4,   ew: 0,   ec: 4};
        vecs[2] = '{addr: 7,  w: 255, inh: 0, gate: 0, n: 1,   ew: 255, ec: 1};
        vecs[3] = '{addr: 8,  w: 128, inh: 0, gate: 0, n: 2,   ew: 255, ec: 2};
        vecs[4] = '{addr: 9,  w: 127, inh: 0, gate: 0, n: 2,   ew: 254, ec: 2};
        vecs[5] = '{addr: 10, w: 200, inh: 0, gate: 0, n: 300, ew: 255, ec: 255};
        vecs[6] = '{addr: 11, w: 255, inh: 1, gate: 0, n: 20,  ew: 0,   ec: 20};
        vecs[7] = '{addr: 12, w: 0,   inh: 0, gate: 0, n: 3,   ew: 0,   ec: 3};
        vecs[8] = '{addr: 0,  w: 9,   inh: 1, gate: 0, n: 0,   ew: 0,   ec: 0};

        // Reset state
        #3;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_weight", int'(out_weight), 0);
        chk("rst_count", int'(out_count), 0);
        chk("rst_overrun", int'(tick_overrun), 0);
        chk("rst_ready", int'(ev_ready), 0);
        #9;
        rst = 1'b1;
        #1;
        chk("rel_ready_before_edge", int'(ev_ready), 0);
        cyc();
        chk("rel_ready_after_edge", int'(ev_ready), 1);

        foreach (vecs[k]) begin
            wr(vecs[k].addr, vecs[k].w, vecs[k].inh);
            wait_ready($sformatf("v%0d", k));
            events(vecs[k].addr, vecs[k].gate, vecs[k].n);
            tick_and_check($sformatf("v%0d", k), vecs[k].ew, vecs[k].ec);
        end

        // Mixed excitatory/inhibitory steps
        wr(1, 200, 0);
        wr(2, 100, 1);
        events(1, 0, 2);
        events(2, 0, 1);
        tick_and_check("t2a", 255, 3);
        events(2, 0, 3);
        tick_and_check("t2b", 0, 3);

        // Event coincident with tick, then a held event through DRAIN/EMIT
        wr(4, 7, 0);
        events(4, 0, 1);
        ev_valid = 1'b1;
        ev_addr  = 4'd4;
        tick     = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t4_drain_ready", int'(ev_ready), 0);
        chk("t4_drain_valid", int'(out_valid), 0);
        cyc();
        chk("t4_emit_ready", int'(ev_ready), 0);
        chk("t4_emit_valid", int'(out_valid), 1);
        chk("t4_emit_weight", int'(out_weight), 14);
        chk("t4_emit_count", int'(out_count), 2);
        cyc();
        chk("t4_accum_ready", int'(ev_ready), 1);
        cyc();
        ev_valid = 1'b0;
        tick_and_check("t4b", 7, 1);

        // Pending tick, overrun, read-before-write
        wr(5, 20, 0);
        ev_valid = 1'b1;
        ev_addr  = 4'd5;
        wr_en    = 1'b1;
        wr_addr  = 4'd5;
        wr_data  = 8'd90;
        wr_inh   = 1'b0;
        cyc();
        ev_valid = 1'b0;
        wr_en    = 1'b0;
        tick     = 1'b1;
        cyc();
        chk("t5_drain_valid", int'(out_valid), 0);
        cyc();
        chk("t5_emit1_valid", int'(out_valid), 1);
        chk("t5_emit1_weight", int'(out_weight), 20);
        chk("t5_emit1_count", int'(out_count), 1);
        chk("t5_overrun_early", int'(tick_overrun), 0);
        cyc();
        tick = 1'b0;
        chk("t5_overrun_set", int'(tick_overrun), 1);
        chk("t5_accum_valid", int'(out_valid), 0);
        chk("t5_accum_ready", int'(ev_ready), 1);
        ev_valid = 1'b1;
        ev_addr  = 4'd5;
        cyc();
        ev_valid = 1'b0;
        chk("t5_drain2_valid", int'(out_valid), 0);
        chk("t5_drain2_ready", int'(ev_ready), 0);
        cyc();
        chk("t5_emit2_valid", int'(out_valid), 1);
        chk("t5_emit2_weight", int'(out_weight), 90);
        chk("t5_emit2_count", int'(out_count), 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (out_valid) pulses++;
        end
        chk("t5_no_third_pulse", pulses, 0);
        chk("t5_overrun_sticky", int'(tick_overrun), 1);

        // Asynchronous reset mid-step with events in flight
        ev_valid = 1'b1;
        ev_addr  = 4'd3;
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_weight", int'(out_weight), 0);
        chk("t6_count", int'(out_count), 0);
        chk("t6_overrun", int'(tick_overrun), 0);
        chk("t6_ready", int'(ev_ready), 0);
        ev_valid = 1'b0;
        cyc();
        cyc();
        chk("t6_ready_held", int'(ev_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ready_pre_edge", int'(ev_ready), 0);
        cyc();
        chk("t6_ready_post", int'(ev_ready), 1);
        tick_and_check("t6a", 0, 0);
        wait_ready("t6b");
        events(1, 0, 1);
        tick_and_check("t6b", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
